// File: rtl/i2s_tx_serializer_if.sv
// Sample-side bundle of the I2S transmitter: strobed two's-complement samples in, advisory ready out.
// No backpressure: ena_i is never stalled, ready_o only reports that the pair buffer is empty.
interface i2s_tx_serializer_if #(
  parameter int D_WIDTH = 24
);
  logic [D_WIDTH-1:0] data_i;
  logic               ena_i;
  logic               ready_o;

  modport master (output data_i, output ena_i, input ready_o);
  modport slave  (input data_i, input ena_i, output ready_o);
endinterface

// File: rtl/i2s_tx_serializer.sv
// Stereo I2S serializer (left-justified when I2S_TX_LEFT_JUSTIFIED_EN is defined) with a one-pair buffer; left MSB
// lands CLK_DIV clocks after the next frame boundary; no backpressure: late right samples are dropped (overrun).
module i2s_tx_serializer #(
  parameter int D_WIDTH    = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int CLK_DIV    = 4
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  i2s_tx_serializer_if.slave smp,
  input  logic               clr_i,
  output logic               sclk_o,
  output logic               lrclk_o,
  output logic               sdata_o,
  output logic               overrun_o,
  output logic               underrun_o
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int DIV_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  localparam int   PAD    = SLOT_WIDTH - D_WIDTH;
  localparam logic LR_RST = 1'b1;
`else
  // One extra slot bit ahead of the MSB carries the I2S delay bit.
  localparam int   PAD    = SLOT_WIDTH - D_WIDTH - 1;
  localparam logic LR_RST = 1'b0;
`endif

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_WIDTH);

  function automatic logic [SLOT_WIDTH-1:0] fmt_slot(input logic [D_WIDTH-1:0] s);
    logic [SLOT_WIDTH-1:0] ext;
    ext              = '0;
    ext[D_WIDTH-1:0] = s;
    return ext << PAD;
  endfunction

  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  toggle_q, toggle_d;
  logic [D_WIDTH-1:0]    left_hold_q, left_hold_d;
  logic [2*D_WIDTH-1:0]  pair_q, pair_d;
  logic                  pend_q, pend_d;
  logic                  seen_q, seen_d;
  logic                  sclk_q, sclk_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic                  ready_q, ready_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;

  logic div_wrap;
  logic boundary;
  logic consume;
  logic accept;
  logic drop;
  logic underrun_set;

  always_comb begin
    div_wrap     = (div_q == DIV_LAST);
    boundary     = div_wrap && (bit_q == BIT_LAST);
    consume      = boundary && pend_q;
    accept       = smp.ena_i && toggle_q && (!pend_q || consume);
    drop         = smp.ena_i && toggle_q && pend_q && !consume;
    underrun_set = 1'b0;

    div_d   = div_wrap ? '0 : div_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pend_d  = pend_q;
    seen_d  = seen_q;

    if (div_wrap) begin
      bit_d   = boundary ? '0 : bit_q + 1'b1;
      shift_d = shift_q << 1;
    end

    // The whole next frame is formatted at once; the shifter then only walks it MSB first.
    if (boundary) begin
      if (pend_q) begin
        shift_d = {fmt_slot(pair_q[2*D_WIDTH-1 -: D_WIDTH]), fmt_slot(pair_q[D_WIDTH-1:0])};
        pend_d  = 1'b0;
        seen_d  = 1'b1;
      end else begin
        shift_d      = '0;
        underrun_set = seen_q;
      end
    end

    toggle_d    = toggle_q ^ smp.ena_i;
    left_hold_d = (smp.ena_i && !toggle_q) ? smp.data_i : left_hold_q;
    pair_d      = accept ? {left_hold_q, smp.data_i} : pair_q;
    if (accept) begin
      pend_d = 1'b1;
    end

    overrun_d  = drop | (overrun_q & ~clr_i);
    underrun_d = underrun_set | (underrun_q & ~clr_i);

    // Serial outputs follow the next-state counters so all three change on the same edge.
    sclk_d  = (div_d >= DIV_HALF);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    lrclk_d = (bit_d < BIT_SLOT);
`else
    lrclk_d = (bit_d >= BIT_SLOT);
`endif
    sdata_d = shift_d[FRAME_BITS-1];
    ready_d = ~pend_d;
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      div_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      toggle_q    <= 1'b0;
      left_hold_q <= '0;
      pair_q      <= '0;
      pend_q      <= 1'b0;
      seen_q      <= 1'b0;
      sclk_q      <= 1'b0;
      lrclk_q     <= LR_RST;
      sdata_q     <= 1'b0;
      ready_q     <= 1'b1;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      toggle_q    <= toggle_d;
      left_hold_q <= left_hold_d;
      pair_q      <= pair_d;
      pend_q      <= pend_d;
      seen_q      <= seen_d;
      sclk_q      <= sclk_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      ready_q     <= ready_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  assign sclk_o      = sclk_q;
  assign lrclk_o     = lrclk_q;
  assign sdata_o     = sdata_q;
  assign smp.ready_o = ready_q;
  assign overrun_o   = overrun_q;
  assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: vector table, directed corner sequences and random traffic vs a frame-level model.
module tb_i2s_tx_serializer;
  localparam int DW    = 24;
  localparam int SLOT  = 32;
  localparam int CD    = 4;
  localparam int FRAME = 2 * SLOT * CD;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  localparam logic LR_RST = 1'b1;
`else
  localparam logic LR_RST = 1'b0;
`endif

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  logic clr  = 1'b0;
  logic sclk, lrclk, sdata, ovr, und;

  i2s_tx_serializer_if #(.D_WIDTH(DW)) smp();

  i2s_tx_serializer #(.D_WIDTH(DW), .SLOT_WIDTH(SLOT), .CLK_DIV(CD)) dut (
    .clk_i      (clk),
    .nrst_i     (nrst),
    .smp        (smp),
    .clr_i      (clr),
    .sclk_o     (sclk),
    .lrclk_o    (lrclk),
    .sdata_o    (sdata),
    .overrun_o  (ovr),
    .underrun_o (und)
  );

  always #5 clk = ~clk;

  int n_pass, n_total, cyc;

  // Frame-level model: which samples each frame carries, plus buffer and flag state.
  logic          m_tog, m_pend, m_seen, m_ovr, m_und;
  logic [DW-1:0] m_left, m_pl, m_pr, m_fl, m_fr;
  logic [SLOT-1:0] cw_l, cw_r, last_l, last_r;

  typedef struct {
    logic [DW-1:0]   l;
    logic [DW-1:0]   r;
    logic [SLOT-1:0] el;
    logic [SLOT-1:0] er;
  } vec_t;
  vec_t tbl[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [5:0] exp_out();
    int p, b, j;
    logic [DW-1:0] s;
    logic sc, lr, sd;
    p  = cyc % FRAME;
    b  = p / CD;
    j  = b % SLOT;
    s  = (b < SLOT) ? m_fl : m_fr;
    sc = (p % CD) >= CD / 2;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    lr = (b < SLOT);
    sd = (j < DW) ? s[DW-1-j] : 1'b0;
`else
    lr = (b >= SLOT);
    sd = (j >= 1 && j <= DW) ? s[DW-j] : 1'b0;
`endif
    return {sc, lr, sd, ~m_pend, m_ovr, m_und};
  endfunction

  task automatic model_reset();
    cyc = 0;
    m_tog = 1'b0; m_pend = 1'b0; m_seen = 1'b0; m_ovr = 1'b0; m_und = 1'b0;
    m_left = '0; m_pl = '0; m_pr = '0; m_fl = '0; m_fr = '0;
    cw_l = '0; cw_r = '0; last_l = '0; last_r = '0;
  endtask

  task automatic model_update(input logic e, input logic [DW-1:0] d, input logic c);
    logic boundary, acc, drop, und_set;
    boundary = (cyc % FRAME) == FRAME - 1;
    acc      = e && m_tog && (!m_pend || boundary);
    drop     = e && m_tog && !acc;
    und_set  = boundary && !m_pend && m_seen;
    if (boundary) begin
      if (m_pend) begin
        m_fl = m_pl; m_fr = m_pr; m_pend = 1'b0; m_seen = 1'b1;
      end else begin
        m_fl = '0; m_fr = '0;
      end
    end
    if (acc) begin
      m_pl = m_left; m_pr = d; m_pend = 1'b1;
    end
    if (e && !m_tog) m_left = d;
    if (e) m_tog = !m_tog;
    m_ovr = drop || (m_ovr && !c);
    m_und = und_set || (m_und && !c);
  endtask

  // One clock: drive inputs, check all outputs against the model, capture the bit the receiver samples.
  task automatic step(input logic e, input logic [DW-1:0] d, input logic c);
    int p, b;
    smp.ena_i  = e;
    smp.data_i = d;
    clr        = c;
    chk("outputs{sclk,lrclk,sdata,ready,ovr,und}", {sclk, lrclk, sdata, smp.ready_o, ovr, und}, exp_out());
    p = cyc % FRAME;
    if (p % CD == CD / 2) begin
      b = p / CD;
      if (b < SLOT) cw_l[SLOT-1-b] = sdata;
      else cw_r[2*SLOT-1-b] = sdata;
    end
    if (p == FRAME - 1) begin
      last_l = cw_l;
      last_r = cw_r;
    end
    model_update(e, d, c);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    nrst = 1'b0; smp.ena_i = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    model_reset();
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {sclk, lrclk, sdata, smp.ready_o, ovr, und}, {1'b0, LR_RST, 1'b0, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0;
    smp.ena_i = 1'b0; smp.data_i = '0;
    model_reset();
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    tbl[0] = '{l: 24'h800001, r: 24'h7FFFFE, el: 32'h80000100, er: 32'h7FFFFE00};
    tbl[1] = '{l: 24'hC00000, r: 24'h000001, el: 32'hC0000000, er: 32'h00000100};
    tbl[2] = '{l: 24'hFFFFFF, r: 24'h123456, el: 32'hFFFFFF00, er: 32'h12345600};
`else
    tbl[0] = '{l: 24'h800001, r: 24'h7FFFFE, el: 32'h40000080, er: 32'h3FFFFF00};
    tbl[1] = '{l: 24'hC00000, r: 24'h000001, el: 32'h60000000, er: 32'h00000080};
    tbl[2] = '{l: 24'hFFFFFF, r: 24'h123456, el: 32'h7FFFFF80, er: 32'h091A2B00};
`endif
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk_reset_vals("reset_values");

    // Pair sent before the first boundary shows up complete in the second frame.
    for (int i = 0; i < 3; i++) begin
      do_reset();
      run_to(3);
      step(1'b1, tbl[i].l, 1'b0);
      step(1'b1, tbl[i].r, 1'b0);
      run_to(2 * FRAME);
      chk($sformatf("tbl%0d_left_slot", i), last_l, tbl[i].el);
      chk($sformatf("tbl%0d_right_slot", i), last_r, tbl[i].er);
    end

    // Three pairs in one frame: first kept, later right samples dropped.
    do_reset();
    run_to(10);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, tbl[k].l, 1'b0);
      step(1'b1, tbl[k].r, 1'b0);
    end
    chk("ovr_flag_set", ovr, 1);
    chk("ovr_ready_low", smp.ready_o, 0);
    run_to(FRAME - 1);
    chk("ovr_ready_low_at_boundary", smp.ready_o, 0);
    run_to(FRAME);
    chk("ovr_ready_after_boundary", smp.ready_o, 1);
    run_to(2 * FRAME);
    chk("ovr_first_pair_left", last_l, tbl[0].el);
    chk("ovr_first_pair_right", last_r, tbl[0].er);

    // One pair then silence: underrun after the pair, cleared by clr_i.
    do_reset();
    run_to(5);
    step(1'b1, tbl[1].l, 1'b0);
    step(1'b1, tbl[1].r, 1'b0);
    run_to(2 * FRAME - 1);
    chk("und_clear_before", und, 0);
    run_to(3 * FRAME);
    chk("und_zero_frame_left", last_l, 0);
    chk("und_zero_frame_right", last_r, 0);
    chk("und_flag_set", und, 1);
    step(1'b0, '0, 1'b1);
    chk("und_cleared_by_clr", und, 0);

    // Right sample exactly on the boundary with the buffer full.
    do_reset();
    run_to(5);
    step(1'b1, tbl[0].l, 1'b0);
    step(1'b1, tbl[0].r, 1'b0);
    run_to(300);
    step(1'b1, tbl[1].l, 1'b0);
    step(1'b1, tbl[1].r, 1'b0);
    run_to(400);
    step(1'b1, tbl[2].l, 1'b0);
    run_to(2 * FRAME - 1);
    step(1'b1, tbl[2].r, 1'b0);
    chk("bnd_no_overrun", ovr, 0);
    chk("bnd_new_pair_pending", smp.ready_o, 0);
    run_to(3 * FRAME);
    chk("bnd_old_pair_left", last_l, tbl[1].el);
    chk("bnd_old_pair_right", last_r, tbl[1].er);
    run_to(4 * FRAME);
    chk("bnd_new_pair_left", last_l, tbl[2].el);
    chk("bnd_new_pair_right", last_r, tbl[2].er);

    // Reset in the middle of a data-carrying left slot with the toggle pointing at right.
    do_reset();
    run_to(5);
    step(1'b1, tbl[2].l, 1'b0);
    step(1'b1, tbl[2].r, 1'b0);
    run_to(260);
    step(1'b1, 24'hABCDEF, 1'b0);
    run_to(300);
    do_reset();
    chk_reset_vals("midframe_reset_values");
    run_to(3);
    step(1'b1, tbl[0].l, 1'b0);
    step(1'b1, tbl[0].r, 1'b0);
    run_to(FRAME);
    chk("midframe_reset_frame0_left", last_l, 0);
    run_to(2 * FRAME);
    chk("midframe_reset_left_first", last_l, tbl[0].el);
    chk("midframe_reset_right_second", last_r, tbl[0].er);

    // Random traffic from overrunning to underrunning rates, with sporadic flag clears.
    do_reset();
    for (int f = 0; f < 12; f++) begin
      int rate;
      rate = (f < 4) ? 40 : ((f < 8) ? 130 : 300);
      for (int k = 0; k < FRAME; k++)
        step($urandom_range(rate - 1, 0) == 0, DW'($urandom), $urandom_range(499, 0) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
